raccoon2axi32_q: RTL and testbench

Queued Raccoon-ring-to-32-bit-AXI3 bridge node. It claims single-word read and write requests whose address falls in a programmable window and buffers them in parameterised read and write queues, so several transactions can be outstanding. It returns AXI R and B beats as Raccoon responses with the error status carried in the response word. It sits on the Raccoon ring in front of an AXI slave or interconnect.

---
 rtl/raccoon2axi32_q.sv | 229 ++++++++++++++++++++++
 tb/tb_raccoon2axi32_q.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raccoon2axi32_q.sv
// raccoon2axi32_q: Raccoon ring node bridging single-word requests in an
// address window onto a 32-bit AXI3 master port, with read/write queues.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   RaccIn / RaccOut    64-bit ring input / registered ring output
//   AW*, W*, B*         AXI3 write address, write data, write response
//   AR*, R*             AXI3 read address, read data
//   Idle                both queues empty and no AW/W half-issued
module raccoon2axi32_q #(
    parameter logic [19:0] ADDR_MASK    = 20'hF0000,
    parameter logic [19:0] ADDR_BASE    = 20'h10000,
    parameter logic [11:0] AXI_UPPER_12 = 12'h000,
    parameter int          RD_DEPTH     = 4,
    parameter int          WR_DEPTH     = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [63:0] RaccIn,
    output logic [63:0] RaccOut,
    output logic [7:0]  AWID,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic [1:0]  AWLOCK,
    output logic [3:0]  AWCACHE,
    output logic [2:0]  AWPROT,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [7:0]  WID,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [7:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY,
    output logic [7:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic [1:0]  ARLOCK,
    output logic [3:0]  ARCACHE,
    output logic [2:0]  ARPROT,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [7:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    output logic        Idle
);

    localparam int RPW = $clog2(RD_DEPTH);
    localparam int RCW = RPW + 1;
    localparam int WPW = $clog2(WR_DEPTH);
    localparam int WCW = WPW + 1;

    logic [63:0] din_q, din_d;
    logic [63:0] racc_out_q, racc_out_d;
    logic        prefer_r_q, prefer_r_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic [RPW-1:0] rd_wp_q, rd_wp_d, rd_rp_q, rd_rp_d;
    logic [RCW-1:0] rd_cnt_q, rd_cnt_d;
    logic [WPW-1:0] wr_wp_q, wr_wp_d, wr_rp_q, wr_rp_d;
    logic [WCW-1:0] wr_cnt_q, wr_cnt_d;

    logic [7:0]  rd_id_mem   [RD_DEPTH];
    logic [31:0] rd_addr_mem [RD_DEPTH];
    logic [7:0]  wr_id_mem   [WR_DEPTH];
    logic [31:0] wr_addr_mem [WR_DEPTH];
    logic [31:0] wr_data_mem [WR_DEPTH];
    logic [3:0]  wr_strb_mem [WR_DEPTH];

    logic [19:0] din_addr;
    logic [31:0] q_addr;
    logic        hit, is_rd;
    logic        rd_full, rd_empty, wr_full, wr_empty;
    logic        rd_push, rd_pop, wr_push, wr_pop;
    logic        aw_hs, w_hs;
    logic        slot_free, r_win, b_win, r_take, b_take;
    logic        unused_ok;

    assign unused_ok = RLAST;

    // Request decode on the registered ring word
    assign din_d    = RaccIn;
    assign din_addr = {din_q[49:32], 2'b00};
    assign q_addr   = {AXI_UPPER_12, din_addr};
    assign is_rd    = (din_q[53:50] == 4'd0);
    assign hit      = (din_q[63:62] == 2'b11) &&
                      ((din_addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));

    assign rd_full  = (rd_cnt_q == RCW'(RD_DEPTH));
    assign rd_empty = (rd_cnt_q == '0);
    assign wr_full  = (wr_cnt_q == WCW'(WR_DEPTH));
    assign wr_empty = (wr_cnt_q == '0);

    // Full is judged on the current count, so a pop this cycle never
    // makes room for a push in the same cycle.
    assign rd_push = hit & is_rd & ~rd_full;
    assign wr_push = hit & ~is_rd & ~wr_full;

    assign ARVALID = ~rd_empty;
    assign rd_pop  = ARVALID & ARREADY;

    assign AWVALID = ~wr_empty & ~aw_done_q;
    assign WVALID  = ~wr_empty & ~w_done_q;
    assign aw_hs   = AWVALID & AWREADY;
    assign w_hs    = WVALID & WREADY;
    // Entry retires once both halves have completed, possibly together
    assign wr_pop  = ~wr_empty & (aw_done_q | aw_hs) & (w_done_q | w_hs);

    // Ring slot can carry a response if empty or freed by our accept
    assign slot_free = ~din_q[63] | rd_push | wr_push;
    assign r_win     = RVALID & (prefer_r_q | ~BVALID);
    assign b_win     = BVALID & (~prefer_r_q | ~RVALID);
    assign r_take    = slot_free & r_win;
    assign b_take    = slot_free & b_win;
    assign RREADY    = r_take & ~RST;
    assign BREADY    = b_take & ~RST;

    assign ARID    = rd_id_mem[rd_rp_q];
    assign ARADDR  = rd_addr_mem[rd_rp_q];
    assign AWID    = wr_id_mem[wr_rp_q];
    assign AWADDR  = wr_addr_mem[wr_rp_q];
    assign WID     = AWID;
    assign WDATA   = wr_data_mem[wr_rp_q];
    assign WSTRB   = wr_strb_mem[wr_rp_q];
    assign WLAST   = 1'b1;

    assign ARLEN   = 4'd0;
    assign ARSIZE  = 3'd2;
    assign ARBURST = 2'd0;
    assign ARLOCK  = 2'd0;
    assign ARCACHE = 4'd0;
    assign ARPROT  = 3'd0;
    assign AWLEN   = 4'd0;
    assign AWSIZE  = 3'd2;
    assign AWBURST = 2'd0;
    assign AWLOCK  = 2'd0;
    assign AWCACHE = 4'd0;
    assign AWPROT  = 3'd0;

    assign RaccOut = racc_out_q;
    assign Idle    = rd_empty & wr_empty & ~aw_done_q & ~w_done_q;

    always_comb begin
        racc_out_d = din_q;
        prefer_r_d = prefer_r_q;
        aw_done_d  = aw_done_q | aw_hs;
        w_done_d   = w_done_q | w_hs;
        rd_wp_d    = rd_wp_q;
        rd_rp_d    = rd_rp_q;
        rd_cnt_d   = rd_cnt_q + RCW'(rd_push) - RCW'(rd_pop);
        wr_wp_d    = wr_wp_q;
        wr_rp_d    = wr_rp_q;
        wr_cnt_d   = wr_cnt_q + WCW'(wr_push) - WCW'(wr_pop);

        if (r_take) begin
            racc_out_d = {2'b10, RID, RRESP, 20'd0, RDATA};
            prefer_r_d = 1'b0;
        end else if (b_take) begin
            racc_out_d = {2'b10, BID, BRESP, 20'd0, 32'd0};
            prefer_r_d = 1'b1;
        end else if (rd_push | wr_push) begin
            racc_out_d = 64'd0;
        end

        if (rd_push) rd_wp_d = rd_wp_q + 1'b1;
        if (rd_pop)  rd_rp_d = rd_rp_q + 1'b1;
        if (wr_push) wr_wp_d = wr_wp_q + 1'b1;
        if (wr_pop) begin
            wr_rp_d   = wr_rp_q + 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            din_q      <= 64'd0;
            racc_out_q <= 64'd0;
            prefer_r_q <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rd_wp_q    <= '0;
            rd_rp_q    <= '0;
            rd_cnt_q   <= '0;
            wr_wp_q    <= '0;
            wr_rp_q    <= '0;
            wr_cnt_q   <= '0;
        end else begin
            din_q      <= din_d;
            racc_out_q <= racc_out_d;
            prefer_r_q <= prefer_r_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            rd_wp_q    <= rd_wp_d;
            rd_rp_q    <= rd_rp_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_wp_q    <= wr_wp_d;
            wr_rp_q    <= wr_rp_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    // Queue storage needs no reset; validity is tracked by the counters
    always_ff @(posedge CLK) begin
        if (rd_push) begin
            rd_id_mem[rd_wp_q]   <= din_q[61:54];
            rd_addr_mem[rd_wp_q] <= q_addr;
        end
        if (wr_push) begin
            wr_id_mem[wr_wp_q]   <= din_q[61:54];
            wr_addr_mem[wr_wp_q] <= q_addr;
            wr_data_mem[wr_wp_q] <= din_q[31:0];
            wr_strb_mem[wr_wp_q] <= din_q[53:50];
        end
    end

endmodule

// File: tb/tb_raccoon2axi32_q.sv
// tb_raccoon2axi32_q: scoreboard bench for raccoon2axi32_q.
// Expected AR/AW/W beats and ring words are queued at stimulus time.
module tb_raccoon2axi32_q;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [63:0] RaccIn = '0;
    logic [63:0] RaccOut;
    logic [7:0]  AWID, WID, ARID;
    logic [31:0] AWADDR, WDATA, ARADDR;
    logic [3:0]  AWLEN, AWCACHE, WSTRB, ARLEN, ARCACHE;
    logic [2:0]  AWSIZE, AWPROT, ARSIZE, ARPROT;
    logic [1:0]  AWBURST, AWLOCK, ARBURST, ARLOCK;
    logic        AWVALID, WLAST, WVALID, BREADY, ARVALID, RREADY, Idle;
    logic        AWREADY = 1'b0;
    logic        WREADY = 1'b0;
    logic        ARREADY = 1'b0;
    logic [7:0]  BID = '0;
    logic [1:0]  BRESP = '0;
    logic        BVALID = 1'b0;
    logic [7:0]  RID = '0;
    logic [31:0] RDATA = '0;
    logic [1:0]  RRESP = '0;
    logic        RLAST = 1'b0;
    logic        RVALID = 1'b0;

    raccoon2axi32_q dut (
        .CLK(CLK), .RST(RST), .RaccIn(RaccIn), .RaccOut(RaccOut),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE),
        .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE),
        .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY), .Idle(Idle)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    logic [39:0] exp_ar[$];
    logic [39:0] exp_aw[$];
    logic [43:0] exp_w[$];
    logic [63:0] exp_ring[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mkreq(input logic [7:0] id,
                                          input logic [3:0] mask,
                                          input logic [19:0] baddr,
                                          input logic [31:0] data);
        return {2'b11, id, mask, baddr[19:2], data};
    endfunction

    function automatic logic [63:0] rsp(input logic [7:0] id,
                                        input logic [1:0] rs,
                                        input logic [31:0] d);
        return {2'b10, id, rs, 20'd0, d};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    // Monitors: handshakes seen at negedge complete on the next posedge
    always @(negedge CLK) begin
        if (!RST) begin
            if (ARVALID && ARREADY) begin
                if (exp_ar.size() == 0) chk("ar_extra", exp_ar.size(), 1);
                else begin
                    chk("ar", {ARID, ARADDR}, exp_ar.pop_front());
                    chk("ar_ctl", {ARLEN, ARSIZE, ARBURST, ARLOCK},
                        {4'd0, 3'd2, 2'd0, 2'd0});
                end
            end
            if (AWVALID && AWREADY) begin
                if (exp_aw.size() == 0) chk("aw_extra", exp_aw.size(), 1);
                else begin
                    chk("aw", {AWID, AWADDR}, exp_aw.pop_front());
                    chk("aw_ctl", {AWLEN, AWSIZE, AWBURST, AWPROT},
                        {4'd0, 3'd2, 2'd0, 3'd0});
                end
            end
            if (WVALID && WREADY) begin
                if (exp_w.size() == 0) chk("w_extra", exp_w.size(), 1);
                else begin
                    chk("w", {WID, WSTRB, WDATA}, exp_w.pop_front());
                    chk("wlast", WLAST, 1);
                end
            end
            if (RREADY && BREADY) chk("rb_both", {RREADY, BREADY}, 0);
            if (RaccOut[63]) begin
                if (exp_ring.size() == 0)
                    chk("ring_extra", RaccOut, 0);
                else
                    chk("ring", RaccOut, exp_ring.pop_front());
            end
        end
    end

    task automatic do_r(input logic [7:0] id, input logic [31:0] d,
                        input logic [1:0] rs);
        logic got;
        exp_ring.push_back(rsp(id, rs, d));
        RID = id; RDATA = d; RRESP = rs; RLAST = 1'b1; RVALID = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge CLK);
            got = RREADY;
            tick();
        end
        RVALID = 1'b0;
        if (!got) chk("r_timeout", got, 1);
    endtask

    task automatic do_b(input logic [7:0] id, input logic [1:0] rs);
        logic got;
        exp_ring.push_back(rsp(id, rs, 32'd0));
        BID = id; BRESP = rs; BVALID = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge CLK);
            got = BREADY;
            tick();
        end
        BVALID = 1'b0;
        if (!got) chk("b_timeout", got, 1);
    endtask

    logic [7:0]  rid_t [2] = '{8'h11, 8'h33};
    logic [31:0] rdat_t[2] = '{32'hA0A0A0A0, 32'h01234567};
    logic [1:0]  rrs_t [2] = '{2'd0, 2'd1};
    logic [7:0]  bid_t [2] = '{8'h22, 8'h44};
    logic [1:0]  brs_t [2] = '{2'd2, 2'd0};

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w;
        int ri, bi;
        logic rh, bh;

        #1 RST = 1'b1;
        #2;
        chk("rst_out", RaccOut, 0);
        chk("rst_valid", {ARVALID, AWVALID, WVALID}, 0);
        chk("rst_idle", Idle, 1);
        @(posedge CLK);
        #1 RST = 1'b0;

        // Single read in window, R response back on ring
        ARREADY = 1'b1;
        exp_ar.push_back({8'h5A, 32'h00010004});
        RaccIn = mkreq(8'h5A, 4'h0, 20'h10004, 32'd0);
        tick();
        RaccIn = '0;
        @(negedge CLK);
        chk("ar_early", ARVALID, 0);
        tick();
        @(negedge CLK);
        chk("ar_t1", ARVALID, 1);
        tick();
        do_r(8'h5A, 32'hDEADBEEF, 2'd0);
        wait_cyc(3);
        chk("idle_rd", Idle, 1);

        // Write with W first, AW held off
        AWREADY = 1'b0;
        WREADY  = 1'b1;
        exp_aw.push_back({8'h77, 32'h00010010});
        exp_w.push_back({8'h77, 4'hF, 32'h12345678});
        RaccIn = mkreq(8'h77, 4'hF, 20'h10010, 32'h12345678);
        tick();
        RaccIn = '0;
        wait_cyc(5);
        chk("aw_hold", AWVALID, 1);
        chk("w_done", WVALID, 0);
        chk("idle_busy", Idle, 0);
        chk("aw_pend", exp_aw.size(), 1);
        chk("w_seen", exp_w.size(), 0);
        AWREADY = 1'b1;
        wait_cyc(3);
        chk("idle_wr", Idle, 1);
        chk("aw_gone", AWVALID, 0);
        do_b(8'h77, 2'd0);

        // Fill read queue: 4 accepted, 2 pass through
        ARREADY = 1'b0;
        for (int k = 0; k < 6; k++) begin
            w = mkreq(8'h60 + 8'(k), 4'h0, 20'h10100 + 20'(4 * k),
                      32'(k));
            if (k < 4) exp_ar.push_back({8'h60 + 8'(k),
                                         32'h00010100 + 32'(4 * k)});
            else exp_ring.push_back(w);
            RaccIn = w;
            tick();
        end
        RaccIn = '0;
        wait_cyc(4);
        chk("rdq_hold", exp_ar.size(), 4);
        chk("rdq_pass", exp_ring.size(), 0);
        ARREADY = 1'b1;
        wait_cyc(8);
        chk("rdq_drain", exp_ar.size(), 0);

        // Out-of-window request passes through, 2-cycle latency
        w = mkreq(8'h12, 4'h3, 20'h20000, 32'hCAFEF00D);
        exp_ring.push_back(w);
        RaccIn = w;
        tick();
        RaccIn = '0;
        tick();
        chk("pt_lat", RaccOut, w);
        chk("pt_noaxi", {ARVALID, AWVALID, WVALID}, 0);
        wait_cyc(3);

        // Reset with queued reads
        ARREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            RaccIn = mkreq(8'h90 + 8'(k), 4'h0, 20'h10200 + 20'(4 * k),
                           32'd0);
            tick();
        end
        RaccIn = '0;
        wait_cyc(3);
        chk("pre_rst_ar", ARVALID, 1);
        RST = 1'b1;
        #1;
        chk("rst_ar", ARVALID, 0);
        chk("rst_racc", RaccOut, 0);
        chk("rst_idle2", Idle, 1);
        RVALID = 1'b1;
        #1;
        chk("rst_rready", RREADY, 0);
        RVALID = 1'b0;
        wait_cyc(2);
        RST = 1'b0;
        ARREADY = 1'b1;
        wait_cyc(10);
        chk("no_stale", ARVALID, 0);

        // R and B together: round-robin starting with R
        exp_ring.push_back(rsp(rid_t[0], rrs_t[0], rdat_t[0]));
        exp_ring.push_back(rsp(bid_t[0], brs_t[0], 32'd0));
        exp_ring.push_back(rsp(rid_t[1], rrs_t[1], rdat_t[1]));
        exp_ring.push_back(rsp(bid_t[1], brs_t[1], 32'd0));
        ri = 0;
        bi = 0;
        for (int c = 0; c < 40 && (ri < 2 || bi < 2); c++) begin
            RVALID = (ri < 2);
            RID    = (ri < 2) ? rid_t[ri] : 8'd0;
            RDATA  = (ri < 2) ? rdat_t[ri] : 32'd0;
            RRESP  = (ri < 2) ? rrs_t[ri] : 2'd0;
            BVALID = (bi < 2);
            BID    = (bi < 2) ? bid_t[bi] : 8'd0;
            BRESP  = (bi < 2) ? brs_t[bi] : 2'd0;
            @(negedge CLK);
            rh = RVALID && RREADY;
            bh = BVALID && BREADY;
            tick();
            if (rh) ri++;
            if (bh) bi++;
        end
        RVALID = 1'b0;
        BVALID = 1'b0;
        chk("rb_count", ri + bi, 4);
        wait_cyc(3);

        chk("left_ring", exp_ring.size(), 0);
        chk("left_ar", exp_ar.size(), 0);
        chk("left_aw", exp_aw.size(), 0);
        chk("left_w", exp_w.size(), 0);
        chk("idle_end", Idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
